start_trigger_gen: RTL and testbench
====================================

Name: start_trigger_gen

Overview:
- Upstream stage of clock_corrector: turns the asynchronous board start button into the clean level `trigger` that clock_corrector consumes.
- Synchronizes and debounces the button, holds `trigger` high for the whole multicore run, and drops it on `run_done`.
- Re-arms only after the button has been released and debounced, so one press gives exactly one run.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on btn_in (minimum 2).
- DEBOUNCE_CYCLES, 1000, consecutive stable samples required for a press or a release (minimum 2).
- CNT_W, 10, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- btn_in  input  1  raw asynchronous start button, active-high.
- run_done  input  1  single-cycle pulse from the matrix-multiply controller when the run completes.
- trigger  output  1  level start to clock_corrector; high from debounced press until run_done.
- trigger_pulse  output  1  one-cycle strobe coincident with the first cycle of trigger high.
- ready  output  1  high when idle and armed for a new press.

Behaviour:
- Reset:
  - Only on a clk edge with rst=1; rst=1 overrides all other inputs.
  - Clears synchronizer flops, the counter and all outputs: trigger=0, trigger_pulse=0, ready=1.
  - State goes to IDLE.
  - Reset mid-run drops trigger after that edge; there is no completion handshake.
- Synchronizer: btn_in passes through SYNC_STAGES flops. btn_s is the last stage. No other logic samples btn_in.
- FSM states: IDLE, DEBOUNCE, TRIGGERED, RELEASE. All outputs are registered.
- IDLE (ready=1, counter=0):
  - btn_s=1 -> DEBOUNCE, counter=1.
- DEBOUNCE:
  - btn_s=0 -> IDLE, counter=0. No trigger.
  - btn_s=1 and counter==DEBOUNCE_CYCLES-1 -> TRIGGERED.
  - Otherwise counter+1.
- TRIGGERED (trigger=1):
  - trigger_pulse=1 only in the first cycle.
  - btn_s is ignored.
  - run_done=1 -> RELEASE; trigger=0 from the next cycle.
- RELEASE (trigger=0, ready=0):
  - Counts consecutive btn_s=0 samples; any btn_s=1 resets the counter to 0.
  - After DEBOUNCE_CYCLES consecutive lows -> IDLE.
- Latency: btn_in held high from just before edge E0 -> trigger=1 after edge E0+SYNC_STAGES+DEBOUNCE_CYCLES-1. The rising edge is seen on the output in the following cycle.
- run_done:
  - Ignored outside TRIGGERED.
  - run_done in the same cycle trigger first rises is honoured: trigger is high for exactly 1 cycle.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- ready = (state==IDLE). trigger = (state==TRIGGERED).

Optional Feature:
- Macro: RUN_COUNT_EN.
- Defined:
  - Adds output run_count [7:0], reset to 0.
  - Increments on every trigger_pulse; 255 wraps to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless stated):
- Reset: hold rst=1 for 3 cycles with btn_in=1 -> trigger=0, trigger_pulse=0, ready=1 throughout.
- Clean press: btn_in 0->1 held -> trigger rises exactly 5 edges after the first sampling edge; trigger_pulse high 1 cycle; ready=0; trigger stays high for 100 cycles with no run_done.
- Glitch: btn_in high 3 cycles then low -> trigger never rises; ready returns to 1. A second 4-cycle-stable press then triggers normally.
- Completion and re-arm:
  - run_done pulse while btn_in still high -> trigger=0 next cycle; no retrigger while btn_in stays high.
  - Release 2 cycles, bounce high 1 cycle, release 4 cycles -> ready=1 only after the 4 clean lows.
  - New press -> triggers again.
- Reset mid-run: rst=1 for 1 cycle while trigger=1 -> trigger=0 after that edge, ready=1. With btn_in still high, a fresh debounce then re-triggers after 5 edges.
- RUN_COUNT_EN defined: 257 complete press/run_done/release cycles -> run_count reads 1 (wrapped through 0).

Source files
------------

// File: rtl/start_trigger_gen.sv
// start_trigger_gen
//
// Front end for clock_corrector. It takes the raw, asynchronous board start
// button and produces a clean run-length `trigger` level:
//   - btn_in is synchronized through SYNC_STAGES flops (btn_s is the last one)
//   - a press must be seen high for DEBOUNCE_CYCLES consecutive samples
//   - trigger then stays high until run_done, ignoring the button
//   - re-arming needs DEBOUNCE_CYCLES consecutive low samples, so a single
//     press can never start more than one run
//
// Optional build macro: RUN_COUNT_EN adds an 8-bit wrapping run counter.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous reset, active-high
//   btn_in        in   raw asynchronous start button, active-high
//   run_done      in   one-cycle completion pulse from the multiply controller
//   trigger       out  level start, high from debounced press until run_done
//   trigger_pulse out  one-cycle strobe on the first cycle trigger is high
//   ready         out  idle and armed for a new press
//   run_count     out  [7:0] number of runs started (RUN_COUNT_EN only)
//
// Handshake: run_done is only acted on while the FSM is in TRIGGERED; it is
// a single-cycle pulse with no ready/ack back to the producer.

module start_trigger_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic       run_done,
`ifdef RUN_COUNT_EN
  output logic [7:0] run_count,
`endif
  output logic       trigger,
  output logic       trigger_pulse,
  output logic       ready
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DEBOUNCE  = 2'd1,
    ST_TRIGGERED = 2'd2,
    ST_RELEASE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   trigger_q, trigger_d;
  logic                   trigger_pulse_q, trigger_pulse_d;
  logic                   ready_q, ready_d;
  logic                   btn_s;

  // Synchronizer: bit 0 samples the pin, the top bit is the only
  // button signal the FSM ever looks at.
  assign btn_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  // Next-state logic. The counter is shared: it counts stable highs in
  // DEBOUNCE and stable lows in RELEASE, and is held at zero elsewhere.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (btn_s) begin
          state_d = ST_DEBOUNCE;
          cnt_d   = CNT_ONE;
        end
      end
      ST_DEBOUNCE: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_TRIGGERED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_TRIGGERED: begin
        cnt_d = '0;
        if (run_done) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Any high sample while releasing restarts the low-count.
        if (btn_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered copies decoded from the next state, so they
  // line up with state_q after each edge.
  always_comb begin
    trigger_d       = (state_d == ST_TRIGGERED);
    trigger_pulse_d = (state_d == ST_TRIGGERED) && (state_q != ST_TRIGGERED);
    ready_d         = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      sync_q          <= '0;
      trigger_q       <= 1'b0;
      trigger_pulse_q <= 1'b0;
      ready_q         <= 1'b1;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      sync_q          <= sync_d;
      trigger_q       <= trigger_d;
      trigger_pulse_q <= trigger_pulse_d;
      ready_q         <= ready_d;
    end
  end

  assign trigger       = trigger_q;
  assign trigger_pulse = trigger_pulse_q;
  assign ready         = ready_q;

`ifdef RUN_COUNT_EN
  logic [7:0] run_count_q, run_count_d;

  // Counts strobes; wraps naturally from 255 to 0.
  always_comb begin
    run_count_d = run_count_q;
    if (trigger_pulse_q) begin
      run_count_d = run_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_count_q <= 8'd0;
    end else begin
      run_count_q <= run_count_d;
    end
  end

  assign run_count = run_count_q;
`endif

endmodule

// File: tb/tb_start_trigger_gen.sv
// Directed bench for start_trigger_gen with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Each step pushes the expected {trigger, trigger_pulse, ready} for the next
// edge and the checker pops it after that edge.

module tb_start_trigger_gen;

  logic clk;
  logic rst;
  logic btn_in;
  logic run_done;
  logic trigger;
  logic trigger_pulse;
  logic ready;
`ifdef RUN_COUNT_EN
  logic [7:0] run_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_q[$];
`ifdef RUN_COUNT_EN
  logic [7:0] cnt_exp_q[$];
`endif

  // Output encodings {trigger, trigger_pulse, ready}
  localparam logic [2:0] O_IDLE  = 3'b001;
  localparam logic [2:0] O_BUSY  = 3'b000;  // DEBOUNCE or RELEASE
  localparam logic [2:0] O_TRIG1 = 3'b110;
  localparam logic [2:0] O_TRIG  = 3'b100;

  start_trigger_gen #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .run_done(run_done),
`ifdef RUN_COUNT_EN
    .run_count(run_count),
`endif
    .trigger(trigger),
    .trigger_pulse(trigger_pulse),
    .ready(ready)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One edge; inputs already set are sampled, outputs checked 1ns later.
  task automatic cyc(input string tag, input logic [2:0] e);
    logic [2:0] obs;
    logic [2:0] exp_v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs   = {trigger, trigger_pulse, ready};
    exp_v = exp_q.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got {trig,pulse,ready}=%b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic cycn(input string tag, input logic [2:0] e, input int n);
    for (int i = 0; i < n; i++) cyc(tag, e);
  endtask

  // Press and hold: 2 sync edges, 3 debounce edges, then trigger.
  task automatic press(input string tag);
    btn_in = 1'b1;
    cycn({tag, "_sync"}, O_IDLE, 2);
    cycn({tag, "_deb"}, O_BUSY, 3);
    cyc({tag, "_rise"}, O_TRIG1);
  endtask

  // run_done then clean release (button dropped right after run_done edge).
  task automatic finish_run(input string tag);
    run_done = 1'b1;
    cyc({tag, "_done"}, O_BUSY);
    run_done = 1'b0;
    btn_in   = 1'b0;
    cycn({tag, "_rel"}, O_BUSY, 5);
    cyc({tag, "_rearm"}, O_IDLE);
  endtask

`ifdef RUN_COUNT_EN
  task automatic check_count(input string tag, input logic [7:0] e);
    logic [7:0] exp_v;
    cnt_exp_q.push_back(e);
    exp_v = cnt_exp_q.pop_front();
    checks++;
    assert (run_count === exp_v) else begin
      errors++;
      $error("FAIL %s: got run_count=%0d expected %0d", tag, run_count, exp_v);
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    btn_in   = 1'b1;
    run_done = 1'b0;

    // Reset held with button pressed
    cycn("reset", O_IDLE, 3);
    rst    = 1'b0;
    btn_in = 1'b0;
    cycn("post_reset", O_IDLE, 3);

    // Glitch: 3 high samples are not enough
    btn_in = 1'b1;
    cycn("glitch_sync", O_IDLE, 2);
    cyc("glitch_deb0", O_BUSY);
    btn_in = 1'b0;
    cycn("glitch_deb", O_BUSY, 2);
    cycn("glitch_back", O_IDLE, 4);

    // Clean press, held 100 cycles without run_done
    press("press1");
    cycn("press1_hold", O_TRIG, 99);

    // run_done while button still high: no retrigger
    run_done = 1'b1;
    cyc("done1", O_BUSY);
    run_done = 1'b0;
    cycn("held_no_retrig", O_BUSY, 10);

    // Release 2, bounce 1, release: re-arm only after 4 clean lows
    btn_in = 1'b0;
    cycn("rel_a", O_BUSY, 2);
    btn_in = 1'b1;
    cyc("bounce", O_BUSY);
    btn_in = 1'b0;
    cycn("rel_b", O_BUSY, 5);
    cyc("rearm", O_IDLE);
    cyc("rearm_hold", O_IDLE);

    // run_done outside TRIGGERED is ignored
    run_done = 1'b1;
    cyc("stray_done", O_IDLE);
    run_done = 1'b0;
    cyc("stray_done_after", O_IDLE);

    // New press; run_done on the first trigger cycle gives a 1-cycle trigger
    press("press2");
    finish_run("press2");

    // Reset mid-run, then fresh debounce with button still high
    press("press3");
    cyc("press3_hold", O_TRIG);
    rst = 1'b1;
    cyc("mid_reset", O_IDLE);
    rst = 1'b0;
    cycn("retrig_sync", O_IDLE, 2);
    cycn("retrig_deb", O_BUSY, 3);
    cyc("retrig_rise", O_TRIG1);
    cyc("retrig_hold", O_TRIG);
    finish_run("press3");

`ifdef RUN_COUNT_EN
    check_count("count_after_reset_run", 8'd1);
    rst = 1'b1;
    cyc("count_reset", O_IDLE);
    rst = 1'b0;
    check_count("count_zero", 8'd0);
    for (int r = 0; r < 257; r++) begin
      press("cnt");
      finish_run("cnt");
      if (r == 0) check_count("count_first", 8'd1);
      if (r == 254) check_count("count_255", 8'd255);
      if (r == 255) check_count("count_wrap0", 8'd0);
    end
    check_count("count_wrap1", 8'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
